// File: rtl/apb_demux_pkg.sv
// Shared types and helpers for the registered APB demux.
package apb_demux_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP,
    DERR
  } apb_demux_state_e;

  // Width of an index/counter covering n values, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decode: inclusive range compare per slave to one-hot hit,
// binary index of the hit and a miss flag.
module apb_addr_decode
  import apb_demux_pkg::*;
#(
  parameter int unsigned                         ADDR_WIDTH = 32,
  parameter int unsigned                         N_SLV      = 2,
  parameter logic [N_SLV-1:0][ADDR_WIDTH-1:0]    ADDR_BEGIN = '0,
  parameter logic [N_SLV-1:0][ADDR_WIDTH-1:0]    ADDR_END   = '0,
  parameter int unsigned                         IDX_W      = clog2_min1(N_SLV)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [N_SLV-1:0]      hit,
  output logic [IDX_W-1:0]      idx,
  output logic                  miss
);

  always_comb begin
    hit = '0;
    idx = '0;
    for (int unsigned i = 0; i < N_SLV; i++) begin
      // Offset compare is wrap-safe and keeps ADDR_END = all-ones legal.
      if ((addr - ADDR_BEGIN[i]) <= (ADDR_END[i] - ADDR_BEGIN[i])) begin
        hit[i] = 1'b1;
        idx    = IDX_W'(i);
      end
    end
    miss = ~|hit;

    assert (N_SLV >= 1);
    for (int unsigned i = 0; i < N_SLV; i++) begin
      assert (ADDR_BEGIN[i] <= ADDR_END[i]);
      for (int unsigned j = i + 1; j < N_SLV; j++) begin
        assert ((ADDR_END[i] < ADDR_BEGIN[j]) || (ADDR_END[j] < ADDR_BEGIN[i]));
      end
    end
  end

endmodule

// File: rtl/apb_demux_cut.sv
// APB4 1-to-N demux with registered request path, per-access timeout and
// PSLVERR completion for decode misses and hung slaves.
module apb_demux_cut
  import apb_demux_pkg::*;
#(
  parameter int unsigned                         ADDR_WIDTH     = 32,
  parameter int unsigned                         DATA_WIDTH     = 32,
  parameter int unsigned                         N_SLV          = 2,
  parameter logic [N_SLV-1:0][ADDR_WIDTH-1:0]    ADDR_BEGIN     = '0,
  parameter logic [N_SLV-1:0][ADDR_WIDTH-1:0]    ADDR_END       = '0,
  parameter int unsigned                         TIMEOUT_CYCLES = 256,
  parameter int unsigned                         STRB_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [ADDR_WIDTH-1:0]                paddr_i,
  input  logic [2:0]                           pprot_i,
  input  logic                                 psel_i,
  input  logic                                 penable_i,
  input  logic                                 pwrite_i,
  input  logic [DATA_WIDTH-1:0]                pwdata_i,
  input  logic [STRB_WIDTH-1:0]                pstrb_i,
  output logic                                 pready_o,
  output logic [DATA_WIDTH-1:0]                prdata_o,
  output logic                                 pslverr_o,
  output logic [N_SLV-1:0][ADDR_WIDTH-1:0]     paddr_o,
  output logic [N_SLV-1:0][2:0]                pprot_o,
  output logic [N_SLV-1:0]                     psel_o,
  output logic [N_SLV-1:0]                     penable_o,
  output logic [N_SLV-1:0]                     pwrite_o,
  output logic [N_SLV-1:0][DATA_WIDTH-1:0]     pwdata_o,
  output logic [N_SLV-1:0][STRB_WIDTH-1:0]     pstrb_o,
  input  logic [N_SLV-1:0]                     pready_i,
  input  logic [N_SLV-1:0][DATA_WIDTH-1:0]     prdata_i,
  input  logic [N_SLV-1:0]                     pslverr_i,
  output logic [N_SLV-1:0]                     timeout_o,
  input  logic                                 timeout_clr_i
);

  localparam int unsigned      IDX_W    = clog2_min1(N_SLV);
  localparam int unsigned      CNT_W    = clog2_min1(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            prot;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] strb;
  } apb_req_t;

  apb_demux_state_e      state_q, state_d;
  apb_req_t              req_q;
  logic [IDX_W-1:0]      idx_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  slverr_q;
  logic [N_SLV-1:0]      timeout_q, timeout_d;
  logic [N_SLV-1:0]      dec_hit;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_miss;
  logic                  start;
  logic                  abort;

  apb_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .N_SLV      (N_SLV),
    .ADDR_BEGIN (ADDR_BEGIN),
    .ADDR_END   (ADDR_END),
    .IDX_W      (IDX_W)
  ) u_decode (
    .addr (paddr_i),
    .hit  (dec_hit),
    .idx  (dec_idx),
    .miss (dec_miss)
  );

  assign start = (state_q == IDLE) && psel_i && !penable_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    unique case (state_q)
      IDLE:   if (start) state_d = dec_miss ? DERR : SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (pready_i[idx_q]) begin
          state_d = RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          state_d = RESP;
          abort   = 1'b1;
        end
      end
      RESP:   state_d = IDLE;
      DERR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A same-cycle clear cannot hide the flag raised by this abort.
    timeout_d = timeout_clr_i ? '0 : timeout_q;
    if (abort) timeout_d[idx_q] = 1'b1;

    assert ($onehot0(dec_hit));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      prdata_q  <= '0;
      slverr_q  <= 1'b0;
      timeout_q <= '0;
    end else begin
      if (start) begin
        req_q.addr  <= paddr_i - ADDR_BEGIN[dec_idx];
        req_q.prot  <= pprot_i;
        req_q.write <= pwrite_i;
        req_q.wdata <= pwdata_i;
        req_q.strb  <= pstrb_i;
        idx_q       <= dec_idx;
      end
      if (state_q == SETUP)       cnt_q <= '0;
      else if (state_q == ACCESS) cnt_q <= cnt_q + CNT_W'(1);
      if (state_q == ACCESS) begin
        if (pready_i[idx_q]) begin
          prdata_q <= prdata_i[idx_q];
          slverr_q <= pslverr_i[idx_q];
        end else if (abort) begin
          prdata_q <= '0;
          slverr_q <= 1'b1;
        end
      end
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    psel_o    = '0;
    penable_o = '0;
    for (int unsigned i = 0; i < N_SLV; i++) begin
      if (idx_q == IDX_W'(i)) begin
        psel_o[i]    = (state_q == SETUP) || (state_q == ACCESS);
        penable_o[i] = (state_q == ACCESS);
      end
    end
    pready_o  = (state_q == RESP) || (state_q == DERR);
    pslverr_o = ((state_q == RESP) && slverr_q) || (state_q == DERR);
    prdata_o  = (state_q == RESP) ? prdata_q : '0;
  end

  assign paddr_o   = {N_SLV{req_q.addr}};
  assign pprot_o   = {N_SLV{req_q.prot}};
  assign pwrite_o  = {N_SLV{req_q.write}};
  assign pwdata_o  = {N_SLV{req_q.wdata}};
  assign pstrb_o   = {N_SLV{req_q.strb}};
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_apb_demux_cut.sv
// Randomized bench for apb_demux_cut: APB master driver, wait-state slave models,
// and a transaction-level reference for routing, latency, responses and timeouts.
module tb_apb_demux_cut;

  localparam int NS = 3;
  localparam int TO = 4;
  localparam logic [NS-1:0][31:0] BEGINS = {32'hFFFF_F000, 32'h0000_1000, 32'h0000_0000};
  localparam logic [NS-1:0][31:0] ENDS   = {32'hFFFF_FFFF, 32'h0000_1FFF, 32'h0000_0FFF};

  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b0;
  logic [31:0]          paddr_i = '0;
  logic [2:0]           pprot_i = '0;
  logic                 psel_i = 1'b0;
  logic                 penable_i = 1'b0;
  logic                 pwrite_i = 1'b0;
  logic [31:0]          pwdata_i = '0;
  logic [3:0]           pstrb_i = '0;
  logic                 pready_o;
  logic [31:0]          prdata_o;
  logic                 pslverr_o;
  logic [NS-1:0][31:0]  paddr_o;
  logic [NS-1:0][2:0]   pprot_o;
  logic [NS-1:0]        psel_o;
  logic [NS-1:0]        penable_o;
  logic [NS-1:0]        pwrite_o;
  logic [NS-1:0][31:0]  pwdata_o;
  logic [NS-1:0][3:0]   pstrb_o;
  logic [NS-1:0]        pready_i = '0;
  logic [NS-1:0][31:0]  prdata_i = '0;
  logic [NS-1:0]        pslverr_i = '0;
  logic [NS-1:0]        timeout_o;
  logic                 timeout_clr_i = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  apb_demux_cut #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .N_SLV          (NS),
    .ADDR_BEGIN     (BEGINS),
    .ADDR_END       (ENDS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .paddr_i       (paddr_i),
    .pprot_i       (pprot_i),
    .psel_i        (psel_i),
    .penable_i     (penable_i),
    .pwrite_i      (pwrite_i),
    .pwdata_i      (pwdata_i),
    .pstrb_i       (pstrb_i),
    .pready_o      (pready_o),
    .prdata_o      (prdata_o),
    .pslverr_o     (pslverr_o),
    .paddr_o       (paddr_o),
    .pprot_o       (pprot_o),
    .psel_o        (psel_o),
    .penable_o     (penable_o),
    .pwrite_o      (pwrite_o),
    .pwdata_o      (pwdata_o),
    .pstrb_o       (pstrb_o),
    .pready_i      (pready_i),
    .prdata_i      (prdata_i),
    .pslverr_i     (pslverr_i),
    .timeout_o     (timeout_o),
    .timeout_clr_i (timeout_clr_i)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave models: ready after wait_cfg ACCESS cycles, fixed response data.
  int          wait_cfg [NS];
  logic [31:0] rdata_cfg[NS];
  logic        err_cfg  [NS];
  int          acc_ctr  [NS];

  initial begin
    for (int i = 0; i < NS; i++) begin
      wait_cfg[i] = 0; rdata_cfg[i] = '0; err_cfg[i] = 1'b0; acc_ctr[i] = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NS; i++) begin
      prdata_i[i]  = rdata_cfg[i];
      pslverr_i[i] = err_cfg[i];
      if (psel_o[i] && penable_o[i]) begin
        pready_i[i] = (acc_ctr[i] == wait_cfg[i]);
        acc_ctr[i]++;
      end else begin
        pready_i[i] = 1'b0;
        acc_ctr[i]  = 0;
      end
    end
  end

  // Downstream monitor, sampled on the falling edge.
  int          mon_setup, mon_acc, mon_bad, mon_sel, mon_idx;
  logic [31:0] mon_addr, mon_wdata;
  logic [2:0]  mon_prot;
  logic        mon_write;
  logic [3:0]  mon_strb;

  always @(negedge clk) begin
    if ($countones(psel_o) > 1 || (penable_o & ~psel_o) != '0) mon_bad++;
    if (psel_o != '0) mon_sel++;
    for (int i = 0; i < NS; i++) begin
      if (psel_o[i] && !penable_o[i]) begin
        mon_setup++;
        mon_idx   = i;
        mon_addr  = paddr_o[i];
        mon_wdata = pwdata_o[i];
        mon_prot  = pprot_o[i];
        mon_write = pwrite_o[i];
        mon_strb  = pstrb_o[i];
      end else if (psel_o[i] && penable_o[i]) begin
        mon_acc++;
        if (paddr_o[i] !== mon_addr || pwdata_o[i] !== mon_wdata) mon_bad++;
      end
    end
  end

  logic [NS-1:0] model_to = '0;

  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                          input logic [3:0] st, input logic [2:0] pr, input int clr_at,
                          output logic [31:0] rd, output logic er, output int lat);
    mon_setup = 0; mon_acc = 0; mon_bad = 0; mon_sel = 0; mon_idx = -1;
    paddr_i = addr; pwrite_i = wr; pwdata_i = wd; pstrb_i = st; pprot_i = pr;
    psel_i = 1'b1; penable_i = 1'b0;
    lat = 0;
    @(posedge clk); #1;
    lat = 1; penable_i = 1'b1;
    timeout_clr_i = (lat == clr_at);
    paddr_i = $urandom; pwdata_i = $urandom;
    while (!pready_o && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      timeout_clr_i = (lat == clr_at);
      paddr_i = $urandom; pwdata_i = $urandom;
    end
    rd = prdata_o; er = pslverr_o;
    @(posedge clk); #1;
    psel_i = 1'b0; penable_i = 1'b0; timeout_clr_i = 1'b0;
  endtask

  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [3:0] st, input logic [2:0] pr, input int w,
                         input logic [31:0] sdata, input logic serr, input int clr_at);
    int s; bit tmo; logic [31:0] rd; logic er; int lat;
    s = -1;
    for (int i = 0; i < NS; i++) if (addr >= BEGINS[i] && addr <= ENDS[i]) s = i;
    for (int i = 0; i < NS; i++) begin
      wait_cfg[i] = w; rdata_cfg[i] = sdata; err_cfg[i] = serr;
    end
    apb_xfer(addr, wr, wd, st, pr, clr_at, rd, er, lat);
    check("sel_onehot", 64'(mon_bad), 64'(0));
    if (s < 0) begin
      check("miss_lat", 64'(lat), 64'(1));
      check("miss_err", 64'(er), 64'(1));
      check("miss_rdata", 64'(rd), 64'(0));
      check("miss_psel", 64'(mon_sel), 64'(0));
    end else begin
      tmo = (w >= TO);
      check("setup_cnt", 64'(mon_setup), 64'(1));
      check("slv_idx", 64'(mon_idx), 64'(s));
      check("paddr", 64'(mon_addr), 64'(addr - BEGINS[s]));
      check("pprot", 64'(mon_prot), 64'(pr));
      check("pwrite", 64'(mon_write), 64'(wr));
      check("pstrb", 64'(mon_strb), 64'(st));
      check("pwdata", 64'(mon_wdata), 64'(wd));
      check("acc_cycles", 64'(mon_acc), 64'(tmo ? TO : w + 1));
      check("latency", 64'(lat), 64'(tmo ? 2 + TO : 3 + w));
      check("prdata", 64'(rd), tmo ? 64'(0) : 64'(sdata));
      check("pslverr", 64'(er), tmo ? 64'(1) : 64'(serr));
      if (tmo) begin
        if (clr_at == TO + 1) model_to = '0;
        model_to[s] = 1'b1;
      end
    end
    check("timeout_o", 64'(timeout_o), 64'(model_to));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sel;
    logic [31:0] a;

    repeat (3) @(posedge clk);
    #1;
    check("rst_pready", 64'(pready_o), 64'(0));
    check("rst_pslverr", 64'(pslverr_o), 64'(0));
    check("rst_prdata", 64'(prdata_o), 64'(0));
    check("rst_psel", 64'(psel_o), 64'(0));
    check("rst_penable", 64'(penable_o), 64'(0));
    check("rst_timeout", 64'(timeout_o), 64'(0));
    check("rst_paddr", 64'(paddr_o[0]), 64'(0));
    rst_ni = 1'b1;

    run_txn(32'h0000_1004, 1'b0, 32'h0, 4'hF, 3'b000, 0, 32'hCAFE_F00D, 1'b0, -1);
    run_txn(32'h0000_0020, 1'b1, 32'h1234_5678, 4'b0101, 3'b010, 3, 32'h0BAD_0BAD, 1'b0, -1);
    run_txn(32'h8000_0000, 1'b0, 32'h0, 4'hF, 3'b000, 0, 32'h5555_AAAA, 1'b0, -1);
    run_txn(32'h0000_1100, 1'b0, 32'h0, 4'hF, 3'b001, 1000, 32'h7777_7777, 1'b0, -1);
    run_txn(32'h0000_1200, 1'b0, 32'h0, 4'hF, 3'b001, 1000, 32'h6666_6666, 1'b0, TO + 1);
    timeout_clr_i = 1'b1;
    @(posedge clk); #1;
    timeout_clr_i = 1'b0;
    model_to = '0;
    check("lone_clear", 64'(timeout_o), 64'(model_to));

    run_txn(32'hFFFF_FFFF, 1'b0, 32'h0, 4'h3, 3'b111, 1, 32'h0000_00FF, 1'b1, -1);
    run_txn(32'h0000_0FFF, 1'b1, 32'hA5A5_A5A5, 4'h8, 3'b100, 4, 32'h1111_1111, 1'b0, -1);
    run_txn(32'h0000_1000, 1'b0, 32'h0, 4'hF, 3'b000, 0, 32'h2222_2222, 1'b1, -1);
    run_txn(32'h0000_2000, 1'b0, 32'h0, 4'hF, 3'b000, 0, 32'h0, 1'b0, -1);
    run_txn(32'hFFFF_EFFF, 1'b1, 32'h3, 4'hF, 3'b000, 0, 32'h0, 1'b0, -1);

    // Reset during downstream ACCESS of a hung slave.
    for (int i = 0; i < NS; i++) wait_cfg[i] = 1000;
    paddr_i = 32'h0000_0010; pwrite_i = 1'b0; psel_i = 1'b1; penable_i = 1'b0;
    @(posedge clk); #1;
    penable_i = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_access", 64'({psel_o[0], penable_o[0]}), 64'(2'b11));
    rst_ni = 1'b0;
    @(posedge clk); #1;
    model_to = '0;
    check("midrst_psel", 64'(psel_o), 64'(0));
    check("midrst_penable", 64'(penable_o), 64'(0));
    check("midrst_pready", 64'(pready_o), 64'(0));
    check("midrst_pslverr", 64'(pslverr_o), 64'(0));
    check("midrst_prdata", 64'(prdata_o), 64'(0));
    check("midrst_timeout", 64'(timeout_o), 64'(model_to));
    check("midrst_paddr", 64'(paddr_o[0]), 64'(0));
    psel_i = 1'b0; penable_i = 1'b0; rst_ni = 1'b1;
    @(posedge clk); #1;
    check("post_rst_pready", 64'(pready_o), 64'(0));
    run_txn(32'h0000_1ABC, 1'b0, 32'h0, 4'hF, 3'b000, 0, 32'hDEAD_BEEF, 1'b0, -1);

    for (int k = 0; k < 80; k++) begin
      sel = int'($urandom_range(0, 3));
      if (sel < NS) a = BEGINS[sel] + ($urandom % (ENDS[sel] - BEGINS[sel] + 32'd1));
      else          a = $urandom_range(32'hFFFF_EFFF, 32'h0000_2000);
      run_txn(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
              3'($urandom_range(0, 7)), int'($urandom_range(0, 5)), $urandom,
              ($urandom_range(0, 3) == 0), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
